// File: rtl/data_memory_bank.sv
// Data memory bank: single-clock word memory with a byte-enabled CPU port,
// a streamed image-load port (writes from address 0) and a full-memory dump port.
// CPU read latency 1 cycle; load stream accepts 1 word/cycle; dump stream emits 1 word per 2 cycles at best.
module data_memory_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic                CLK,
   input  logic                RST_N,
   // CPU port
   input  logic                WE,
   input  logic [DATA_W/8-1:0] BE,
   input  logic [ADDR_W-1:0]   ADDRESS,
   input  logic [DATA_W-1:0]   DATA,
   output logic [DATA_W-1:0]   Q,
   // image load stream
   input  logic                LOAD_START,
   input  logic                LOAD_VALID,
   input  logic [DATA_W-1:0]   LOAD_DATA,
   input  logic                LOAD_LAST,
   output logic                LOAD_READY,
   // memory dump stream
   input  logic                DUMP_START,
   output logic                DUMP_VALID,
   output logic [DATA_W-1:0]   DUMP_DATA,
   output logic                DUMP_LAST,
   input  logic                DUMP_READY,
   // status
   output logic                BUSY
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DUMP_RD,
      ST_DUMP_OUT
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   ptr;
   logic [ADDR_W-1:0]   ptr_nxt;
   logic                load_acc;
   logic                cpu_wr;

   // Storage has no reset: contents survive RST_N so a partial image stays usable.
   logic [DATA_W-1:0]   mem [DEPTH];

   // State and pointer register; reset aborts any transfer in progress.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next-state and pointer logic; LOAD_START has priority over DUMP_START.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      load_acc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (LOAD_START) begin
               state_nxt = ST_LOAD;
               ptr_nxt   = '0;
            end else if (DUMP_START) begin
               state_nxt = ST_DUMP_RD;
               ptr_nxt   = '0;
            end
         end
         ST_LOAD: begin
            if (LOAD_VALID) begin
               load_acc = 1'b1;
               // The top word ends the load even without LOAD_LAST, so the pointer never wraps.
               if (LOAD_LAST || (ptr == LAST_ADDR)) begin
                  state_nxt = ST_IDLE;
               end else begin
                  ptr_nxt = ptr + 1'b1;
               end
            end
         end
         ST_DUMP_RD: begin
            state_nxt = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (DUMP_READY) begin
               if (DUMP_LAST) begin
                  state_nxt = ST_IDLE;
               end else begin
                  ptr_nxt   = ptr + 1'b1;
                  state_nxt = ST_DUMP_RD;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // CPU writes are only honoured while idle; RST_N gates them so reset never corrupts data.
   assign cpu_wr = RST_N && (state == ST_IDLE) && WE;

   // Memory write port: byte-masked CPU writes in IDLE, whole-word stream writes in LOAD.
   always_ff @(posedge CLK) begin
      if (cpu_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (BE[i]) begin
               mem[ADDRESS][8*i +: 8] <= DATA[8*i +: 8];
            end
         end
      end else if (RST_N && load_acc) begin
         mem[ptr] <= LOAD_DATA;
      end
   end

   // CPU read register: samples pre-write data while idle, holds otherwise.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q <= '0;
      end else if (state == ST_IDLE) begin
         Q <= mem[ADDRESS];
      end
   end

   // Dump output register: fetched in DUMP_RD, held steady through the DUMP_OUT stall.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DUMP_DATA <= '0;
         DUMP_LAST <= 1'b0;
      end else if (state == ST_DUMP_RD) begin
         DUMP_DATA <= mem[ptr];
         DUMP_LAST <= (ptr == LAST_ADDR);
      end
   end

   assign LOAD_READY = (state == ST_LOAD);
   assign DUMP_VALID = (state == ST_DUMP_OUT);
   assign BUSY       = (state != ST_IDLE);

endmodule

// File: doc/data_memory_bank.md
DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port WE  input  1  CPU write enable.
REQ-006 SHALL have port BE  input  DATA_W/8  CPU byte enables; bit i covers DATA[8i+7:8i].
REQ-007 SHALL have port ADDRESS  input  ADDR_W  CPU word address.
REQ-008 SHALL have port DATA  input  DATA_W  CPU write data.
REQ-009 SHALL have port Q  output  DATA_W  registered CPU read data.
REQ-010 SHALL have port LOAD_START  input  1  request image load, starting at address 0.
REQ-011 SHALL have ports LOAD_VALID in 1, LOAD_DATA in DATA_W, LOAD_LAST in 1, LOAD_READY out 1  load stream.
REQ-012 SHALL have port DUMP_START  input  1  request full-memory dump.
REQ-013 SHALL have ports DUMP_VALID out 1, DUMP_DATA out DATA_W, DUMP_LAST out 1, DUMP_READY in 1  dump stream.
REQ-014 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DUMP_RD, DUMP_OUT, plus an internal ADDR_W-bit pointer PTR.
REQ-016 In IDLE: WE=1 writes each byte of mem[ADDRESS] whose BE bit is 1; bytes with BE=0 unchanged.
REQ-017 In IDLE: Q <= mem[ADDRESS] every cycle, latency 1; read-during-write to same address returns old data.
REQ-018 Outside IDLE: WE ignored, Q holds its last value.
REQ-019 IDLE->LOAD on LOAD_START; PTR<=0; LOAD_START and DUMP_START same cycle: LOAD wins.
REQ-020 IDLE->DUMP_RD on DUMP_START (LOAD_START low); PTR<=0.
REQ-021 START inputs outside IDLE SHALL be ignored.
REQ-022 LOAD_READY=1 only in LOAD; each cycle LOAD_VALID&LOAD_READY writes full word LOAD_DATA to mem[PTR], PTR<=PTR+1.
REQ-023 LOAD->IDLE after accepted word with LOAD_LAST=1 or PTR=DEPTH-1; PTR never wraps; no further writes.
REQ-024 DUMP_RD: DUMP_DATA <= mem[PTR], DUMP_LAST <= (PTR==DEPTH-1), next state DUMP_OUT.
REQ-025 DUMP_OUT: DUMP_VALID=1; DUMP_DATA/DUMP_LAST stable until DUMP_READY=1.
REQ-026 DUMP_OUT handshake: if DUMP_LAST, ->IDLE; else PTR<=PTR+1, ->DUMP_RD (throughput 1 word per 2 cycles minimum).
REQ-027 DUMP_VALID SHALL be 0 in all states except DUMP_OUT.

Reset
REQ-028 RST_N=0 SHALL immediately force state IDLE, PTR=0, Q=0, DUMP_DATA=0, DUMP_VALID=0, DUMP_LAST=0, LOAD_READY=0, BUSY=0.
REQ-029 Reset SHALL NOT clear memory contents; reset mid-LOAD keeps words already written, aborts rest.
REQ-030 First operation after RST_N rises SHALL occur on the first rising CLK with RST_N=1.

Verification
REQ-031 Write 0xDEADBEEF @5, BE=4'b1111, then read @5 -> Q=0xDEADBEEF one cycle after the read address is applied.
REQ-032 After REQ-031, write 0x00000011 @5 BE=4'b0001 -> Q=0xDEADBE11; simultaneous read of @5 during that write -> old 0xDEADBEEF.
REQ-033 LOAD_START, stream 0x1,0x2,0x3 with LOAD_LAST on 0x3, VALID gapped every other cycle -> mem[0..2]=1,2,3, BUSY falls cycle after last accept, mem[3] unchanged.
REQ-034 DUMP_START with ADDR_W=2, DUMP_READY held low 3 cycles on word 1 -> words 0..3 emitted in order, DUMP_DATA stable while stalled, DUMP_LAST only on word 3, then IDLE.
REQ-035 LOAD_START and DUMP_START same cycle -> LOAD entered, DUMP_VALID stays 0; WE=1 during LOAD -> memory unchanged at ADDRESS.
REQ-036 RST_N low after 2 of 4 load words -> all outputs 0 immediately, mem[0..1] retain loaded data, next LOAD_START restarts at address 0.
